// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OpMulS = 2'b00;
    localparam logic [1:0] OpMulU = 2'b01;
    localparam logic [1:0] OpDivS = 2'b10;
    localparam logic [1:0] OpDivU = 2'b11;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRun   = 3'd2,
        StFixup = 3'd3,
        StDone  = 3'd4
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OpDivS) || (op == OpDivU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OpMulS) || (op == OpDivS);
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate; yields a magnitude or re-applies a sign.
module muldiv_abs #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = negate ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Radix-2 sequential multiplier/divider: signs stripped in LOAD, one bit per RUN
// cycle through a shared adder, signs restored in FIXUP.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d, wlo_q, wlo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              is_div, is_signed;
    logic [WIDTH-1:0]  mag_a, mag_b, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]    add_x, add_y, add_sum, pp;
    logic              add_sub, div_ok;

    assign is_div    = op_is_div(op_q);
    assign is_signed = op_is_signed(op_q);

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value  (a_q),
        .negate (is_signed & a_q[WIDTH-1]),
        .result (mag_a)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value  (b_q),
        .negate (is_signed & b_q[WIDTH-1]),
        .result (mag_b)
    );

    muldiv_abs #(.WIDTH(2 * WIDTH)) u_fix_prod (
        .value  ({acc_q, wlo_q}),
        .negate (is_signed & (sa_q ^ sb_q)),
        .result (prod_fix)
    );

    muldiv_abs #(.WIDTH(WIDTH)) u_fix_quot (
        .value  (wlo_q),
        .negate (is_signed & (sa_q ^ sb_q)),
        .result (quot_fix)
    );

    // Remainder follows the dividend's sign.
    muldiv_abs #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (acc_q),
        .negate (is_signed & sa_q),
        .result (rem_fix)
    );

    // Shared adder: acc + multiplicand for mult, {rem,next bit} - divisor for div.
    always_comb begin
        add_y   = {1'b0, opnd_q};
        add_sub = is_div;
        add_x   = is_div ? {acc_q, wlo_q[WIDTH-1]} : {1'b0, acc_q};
        add_sum = add_x + (add_y ^ {(WIDTH+1){add_sub}}) + {{WIDTH{1'b0}}, add_sub};
    end

    // A set top bit in the shifted remainder already exceeds any WIDTH-bit divisor.
    assign div_ok = add_x[WIDTH] | ~add_sum[WIDTH];
    assign pp     = wlo_q[0] ? add_sum : {1'b0, acc_q};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        wlo_d   = wlo_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    dz_d    = 1'b0;
                end
            end
            StLoad: begin
                sa_d   = is_signed & a_q[WIDTH-1];
                sb_d   = is_signed & b_q[WIDTH-1];
                acc_d  = '0;
                wlo_d  = mag_a;
                opnd_d = mag_b;
                cnt_d  = CntW'(WIDTH);
                if (is_div && (b_q == '0)) begin
                    dz_d    = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (is_div) begin
                    acc_d = div_ok ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
                    wlo_d = {wlo_q[WIDTH-2:0], div_ok};
                end else begin
                    acc_d = pp[WIDTH:1];
                    wlo_d = {pp[0], wlo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            wlo_q  <= '0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            wlo_q  <= wlo_d;
            opnd_q <= opnd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            dz_q   <= dz_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        hi       = hi_q;
        lo       = lo_q;
        div_zero = dz_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at WIDTH=32 and WIDTH=8.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start32, start8;
    logic [1:0]  op32, op8;
    logic [31:0] a32, b32, hi32, lo32;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy32, done32, dz32, busy8, done8, dz8;

    int n_cmp;
    int n_bad;

    muldiv_seq #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .reset    (reset),
        .start    (start32),
        .op       (op32),
        .a        (a32),
        .b        (b32),
        .busy     (busy32),
        .done     (done32),
        .hi       (hi32),
        .lo       (lo32),
        .div_zero (dz32)
    );

    muldiv_seq #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .op       (op8),
        .a        (a8),
        .b        (b8),
        .busy     (busy8),
        .done     (done8),
        .hi       (hi8),
        .lo       (lo8),
        .div_zero (dz8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, return the cycle (after E0) in which done was seen; 0 on timeout.
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int dcyc, output int bbad);
        @(negedge clk);
        op32 = o; a32 = x; b32 = y; start32 = 1'b1;
        @(posedge clk);
        dcyc = 0;
        bbad = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start32 = 1'b0;
            if (busy32 !== 1'b1) bbad++;
            if (done32 === 1'b1) begin
                dcyc = c;
                break;
            end
        end
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int dcyc);
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk);
        dcyc = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8 === 1'b1) begin
                dcyc = c;
                break;
            end
        end
    endtask

    initial begin
        int dcyc, bbad, npulse;
        logic [31:0] hv, lv;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        start8 = 1'b0;  op8 = 2'b00;  a8 = '0;  b8 = '0;

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_dz", 64'(dz32), 64'd0);
        chk("rst_hilo", {hi32, lo32}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Unsigned max * max.
        run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dcyc, bbad);
        chk("mulu_cyc", 64'(dcyc), 64'd35);
        chk("mulu_busy", 64'(bbad), 64'd0);
        chk("mulu_hilo", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        chk("mulu_done_once", 64'(done32), 64'd0);
        chk("mulu_idle", 64'(busy32), 64'd0);

        // Signed -3 * 5 = -15.
        run32(2'b00, 32'hFFFF_FFFD, 32'd5, dcyc, bbad);
        chk("muls_cyc", 64'(dcyc), 64'd35);
        chk("muls_hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Signed -7 / 2: q=-3, r=-1.
        run32(2'b10, 32'hFFFF_FFF9, 32'd2, dcyc, bbad);
        chk("divs_cyc", 64'(dcyc), 64'd35);
        chk("divs_hilo", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("divs_dz", 64'(dz32), 64'd0);

        // Unsigned 0x56781234 / 0x10000 leaves hi=0x1234, lo=0x5678.
        run32(2'b11, 32'h5678_1234, 32'h0001_0000, dcyc, bbad);
        chk("divu_hilo", {hi32, lo32}, 64'h0000_1234_0000_5678);

        // Divide by zero.
        run32(2'b11, 32'd7, 32'd0, dcyc, bbad);
        chk("dz_cyc", 64'(dcyc), 64'd2);
        chk("dz_flag", 64'(dz32), 64'd1);
        chk("dz_hilo", {hi32, lo32}, 64'h0000_1234_0000_5678);
        repeat (3) @(negedge clk);
        chk("hold_hilo", {hi32, lo32}, 64'h0000_1234_0000_5678);
        chk("hold_dz", 64'(dz32), 64'd1);

        // MIN / -1 wraps to MIN; flag cleared by the new op.
        run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, dcyc, bbad);
        chk("minneg1_cyc", 64'(dcyc), 64'd35);
        chk("minneg1_hilo", {hi32, lo32}, 64'h0000_0000_8000_0000);
        chk("minneg1_dz", 64'(dz32), 64'd0);

        // start pulsed in cycle 10 is neither accepted nor queued.
        @(negedge clk);
        op32 = 2'b01; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
        @(posedge clk);
        npulse = 0;
        dcyc = 0;
        hv = '0;
        lv = '0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start32 = (c == 10);
            if (c == 10) begin
                op32 = 2'b00; a32 = 32'd7; b32 = 32'd7;
            end
            if (done32 === 1'b1) begin
                npulse++;
                if (dcyc == 0) begin
                    dcyc = c; hv = hi32; lv = lo32;
                end
            end
        end
        chk("busy_start_pulses", 64'(npulse), 64'd1);
        chk("busy_start_cyc", 64'(dcyc), 64'd35);
        chk("busy_start_hilo", {hv, lv}, 64'd15);

        // Reset in cycle 5 aborts the op.
        @(negedge clk);
        op32 = 2'b00; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start32 = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_hilo", {hi32, lo32}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        npulse = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done32 === 1'b1) npulse++;
        end
        chk("abort_no_done", 64'(npulse), 64'd0);

        // Signed 100 / -7: q=-14, r=2.
        run32(2'b10, 32'd100, 32'hFFFF_FFF9, dcyc, bbad);
        chk("after_rst_cyc", 64'(dcyc), 64'd35);
        chk("after_rst_hilo", {hi32, lo32}, 64'h0000_0002_FFFF_FFF2);

        // start held in the done cycle is ignored.
        start32 = 1'b1; op32 = 2'b01; a32 = 32'd2; b32 = 32'd2;
        @(negedge clk);
        chk("done_start_ignored", 64'(busy32), 64'd0);
        start32 = 1'b0;

        // WIDTH=8 instance.
        run8(2'b01, 8'hFF, 8'hFF, dcyc);
        chk("w8_mulu_cyc", 64'(dcyc), 64'd11);
        chk("w8_mulu_hilo", 64'({hi8, lo8}), 64'hFE01);
        run8(2'b00, 8'h80, 8'h80, dcyc);
        chk("w8_muls_hilo", 64'({hi8, lo8}), 64'h4000);
        run8(2'b10, 8'hF3, 8'd4, dcyc);
        chk("w8_divs_hilo", 64'({hi8, lo8}), 64'hFFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
